// File: rtl/fir_coef_ctrl.sv
// Runtime coefficient controller for the Tx FIR.
// Coefficients stream into a shadow bank, swap atomically into the active bank
// on a sample-boundary strobe, and out_valid is held low while the FIR delay
// line drains products computed from the previous bank.
module fir_coef_ctrl #(
    parameter int H         = 13,
    parameter int CW        = 9,
    parameter int DEF_C0    = 128,
    parameter int FLUSH_CYC = H + 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_start,
    input  logic            cfg_valid,
    input  logic [CW-1:0]   cfg_data,
    output logic            cfg_ready,
    input  logic            sample_en,
    output logic [H*CW-1:0] coeffs_flat,
    output logic            out_valid,
    output logic            cfg_done,
    output logic            cfg_err,
    output logic            busy
);

    localparam int IDX_W = $clog2(H);
    localparam int CNT_W = $clog2(FLUSH_CYC + 1);

    localparam logic [CW-1:0]    DEF_C0_V   = CW'(DEF_C0);
    localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(H - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ARMED = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              cfg_done_q, cfg_done_d;
    logic              cfg_err_q, cfg_err_d;
    logic              busy_q, busy_d;
    // Set by reset so the flush that follows reset does not report cfg_done.
    logic              boot_q, boot_d;

    logic [CW-1:0]     shadow_q [H];
    logic [CW-1:0]     shadow_d [H];
    logic [CW-1:0]     active_q [H];
    logic [CW-1:0]     active_d [H];

    // A restart request in LOAD takes priority over a coincident beat.
    logic beat;
    logic last_beat;
    logic swap;

    assign beat      = (state_q == S_LOAD) && cfg_valid && cfg_ready_q && !cfg_start;
    assign last_beat = beat && (idx_q == LAST_IDX);
    assign swap      = (state_q == S_ARMED) && sample_en;

    // State register; reset lands in FLUSH so the FIR drains its power-up contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FLUSH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cfg_start)      state_d = S_LOAD;
            S_LOAD:  if (last_beat)      state_d = S_ARMED;
            S_ARMED: if (sample_en)      state_d = S_FLUSH;
            S_FLUSH: if (cnt_q == '0)    state_d = S_IDLE;
            default:                     state_d = S_IDLE;
        endcase
    end

    // Output and counter next values; every output is registered from these.
    always_comb begin
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        cfg_ready_d = cfg_ready_q;
        out_valid_d = out_valid_q;
        cfg_done_d  = 1'b0;
        cfg_err_d   = 1'b0;
        boot_d      = boot_q;
        busy_d      = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    idx_d       = '0;
                    cfg_ready_d = 1'b1;
                end
            end
            S_LOAD: begin
                if (cfg_start) begin
                    cfg_err_d = 1'b1;
                    idx_d     = '0;
                end else if (beat) begin
                    if (last_beat) begin
                        cfg_ready_d = 1'b0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_ARMED: begin
                if (cfg_start) begin
                    cfg_err_d = 1'b1;
                end
                if (sample_en) begin
                    out_valid_d = 1'b0;
                    cnt_d       = FLUSH_INIT;
                end
            end
            S_FLUSH: begin
                if (cfg_start) begin
                    cfg_err_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    out_valid_d = 1'b1;
                    cfg_done_d  = !boot_q;
                    boot_d      = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                cfg_ready_d = 1'b0;
            end
        endcase
    end

    // Per-tap bank update: shadow takes the beat addressed by idx, active copies
    // the whole shadow only on the swap cycle so the FIR never sees a mixed bank.
    generate
        for (genvar gi = 0; gi < H; gi++) begin : g_tap
            always_comb begin
                shadow_d[gi] = shadow_q[gi];
                if (beat && (idx_q == IDX_W'(gi))) begin
                    shadow_d[gi] = cfg_data;
                end
            end

            always_comb begin
                active_d[gi] = active_q[gi];
                if (swap) begin
                    active_d[gi] = shadow_q[gi];
                end
            end

            assign coeffs_flat[(H-1-gi)*CW +: CW] = active_q[gi];
        end
    endgenerate

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= '0;
            cnt_q       <= FLUSH_INIT;
            cfg_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            cfg_done_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            busy_q      <= 1'b1;
            boot_q      <= 1'b1;
            for (int i = 0; i < H; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= (i == 0) ? DEF_C0_V : '0;
            end
        end else begin
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            cfg_ready_q <= cfg_ready_d;
            out_valid_q <= out_valid_d;
            cfg_done_q  <= cfg_done_d;
            cfg_err_q   <= cfg_err_d;
            busy_q      <= busy_d;
            boot_q      <= boot_d;
            for (int i = 0; i < H; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign out_valid = out_valid_q;
    assign cfg_done  = cfg_done_q;
    assign cfg_err   = cfg_err_q;
    assign busy      = busy_q;

endmodule
